digital_clock_ctrl_sar: RTL

Time-set controller that sequences digital_clock_counter_sar. It gates the counter's count enable from a 1 Hz tick and runs a button-driven set mode. Set mode freezes the clock, edits a shadow copy of hour/min/sec in packed BCD, and commits it with a one-cycle load. It sits between the debounced button inputs, the tick generator and the counter/display.

---
 rtl/digital_clock_ctrl_sar_pkg.sv | 27 ++
 rtl/digital_clock_ctrl_sar_bcd_inc.sv | 24 ++
 rtl/digital_clock_ctrl_sar.sv | 165 ++++++++++++++++
 3 files changed

// File: rtl/digital_clock_ctrl_sar_pkg.sv
// Shared encodings and limits for the time-set controller and its BCD incrementer.
package digital_clock_ctrl_pkg_sar;

    localparam logic [2:0] ST_RUN     = 3'd0;
    localparam logic [2:0] ST_SET_HR  = 3'd1;
    localparam logic [2:0] ST_SET_MIN = 3'd2;
    localparam logic [2:0] ST_SET_SEC = 3'd3;
    localparam logic [2:0] ST_COMMIT  = 3'd4;

    typedef enum logic [2:0] {
        RUN     = ST_RUN,
        SET_HR  = ST_SET_HR,
        SET_MIN = ST_SET_MIN,
        SET_SEC = ST_SET_SEC,
        COMMIT  = ST_COMMIT
    } state_t;

    localparam logic [7:0] HOUR_MAX   = 8'h23;
    localparam logic [7:0] MINSEC_MAX = 8'h59;

    typedef struct packed {
        logic [7:0] hour;
        logic [7:0] min;
        logic [7:0] sec;
    } bcd_time_t;

endpackage

// File: rtl/digital_clock_ctrl_sar_bcd_inc.sv
// Packed-BCD increment with wrap at max_val; invalid or out-of-range values wrap to 00.
module bcd_inc_sar (
    input  logic [7:0] value,
    input  logic [7:0] max_val,
    output logic [7:0] result
);

    logic [3:0] hi;
    logic [3:0] lo;

    assign hi = value[7:4];
    assign lo = value[3:0];

    always_comb begin
        if ((value >= max_val) || (hi > 4'd9) || (lo > 4'd9)) begin
            result = 8'h00;
        end else if (lo == 4'd9) begin
            result = {hi + 4'd1, 4'h0};
        end else begin
            result = {hi, lo + 4'd1};
        end
    end

endmodule

// File: rtl/digital_clock_ctrl_sar.sv
// Time-set controller: gates the counter enable from the 1 Hz tick and runs the
// button-driven edit of a shadow hour/min/sec copy, committed with a one-cycle load.
//
//   state   | meaning
//   --------+-----------------------------------------------------------
//   RUN     | clock counting, cnt_en follows tick_1hz
//   SET_HR  | clock frozen, inc edits shadow hour
//   SET_MIN | clock frozen, inc edits shadow minute
//   SET_SEC | clock frozen, inc edits shadow second
//   COMMIT  | one cycle: load strobe with shadow values, tick dropped
module digital_clock_ctrl_sar
    import digital_clock_ctrl_pkg_sar::*;
#(
    parameter int TIMEOUT_TICKS = 10
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       tick_1hz,
    input  logic       btn_mode,
    input  logic       btn_inc,
    input  logic [7:0] cur_hour,
    input  logic [7:0] cur_min,
    input  logic [7:0] cur_sec,
    output logic       cnt_en,
    output logic       load,
    output logic [7:0] load_hour,
    output logic [7:0] load_min,
    output logic [7:0] load_sec,
    output logic [1:0] mode,
    output logic       blink
);

    localparam logic [7:0] TIMEOUT_LIMIT = 8'(TIMEOUT_TICKS);

    state_t     state_q, state_d;
    bcd_time_t  shadow_q, shadow_d;
    bcd_time_t  load_val_q, load_val_d;
    logic [7:0] timeout_q, timeout_d;
    logic       blink_q, blink_d;
    logic       btn_mode_q, btn_mode_d;
    logic       btn_inc_q, btn_inc_d;

    logic       mode_edge;
    logic       inc_edge;
    logic [7:0] inc_field;
    logic [7:0] inc_max;
    logic [7:0] inc_result;

    assign mode_edge = btn_mode & ~btn_mode_q;
    assign inc_edge  = btn_inc & ~btn_inc_q;

    always_comb begin
        inc_field = shadow_q.sec;
        inc_max   = MINSEC_MAX;
        case (state_q)
            SET_HR: begin
                inc_field = shadow_q.hour;
                inc_max   = HOUR_MAX;
            end
            SET_MIN: inc_field = shadow_q.min;
            default: ;
        endcase
    end

    bcd_inc_sar u_bcd_inc (
        .value   (inc_field),
        .max_val (inc_max),
        .result  (inc_result)
    );

    always_comb begin
        state_d    = state_q;
        shadow_d   = shadow_q;
        load_val_d = load_val_q;
        timeout_d  = timeout_q;
        blink_d    = blink_q;
        btn_mode_d = btn_mode;
        btn_inc_d  = btn_inc;

        case (state_q)
            RUN: begin
                if (mode_edge) begin
                    shadow_d  = {cur_hour, cur_min, cur_sec};
                    timeout_d = 8'd0;
                    blink_d   = 1'b0;
                    state_d   = SET_HR;
                end
            end
            SET_HR, SET_MIN, SET_SEC: begin
                if (tick_1hz) begin
                    blink_d = ~blink_q;
                end
                // Mode beats inc, and any edge beats the terminal tick.
                if (mode_edge) begin
                    timeout_d = 8'd0;
                    case (state_q)
                        SET_HR:  state_d = SET_MIN;
                        SET_MIN: state_d = SET_SEC;
                        default: begin
                            state_d    = COMMIT;
                            load_val_d = shadow_q;
                            blink_d    = 1'b0;
                        end
                    endcase
                end else if (inc_edge) begin
                    timeout_d = 8'd0;
                    case (state_q)
                        SET_HR:  shadow_d.hour = inc_result;
                        SET_MIN: shadow_d.min  = inc_result;
                        default: shadow_d.sec  = inc_result;
                    endcase
                end else if (tick_1hz) begin
                    timeout_d = timeout_q + 8'd1;
                    if (timeout_d >= TIMEOUT_LIMIT) begin
                        state_d = RUN;
                        blink_d = 1'b0;
                    end
                end
            end
            COMMIT: state_d = RUN;
            default: begin
                state_d = RUN;
                blink_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= RUN;
            shadow_q   <= '0;
            load_val_q <= '0;
            timeout_q  <= 8'd0;
            blink_q    <= 1'b0;
            btn_mode_q <= 1'b1;
            btn_inc_q  <= 1'b1;
        end else begin
            state_q    <= state_d;
            shadow_q   <= shadow_d;
            load_val_q <= load_val_d;
            timeout_q  <= timeout_d;
            blink_q    <= blink_d;
            btn_mode_q <= btn_mode_d;
            btn_inc_q  <= btn_inc_d;
        end
    end

    always_comb begin
        mode = 2'd0;
        case (state_q)
            SET_HR:  mode = 2'd1;
            SET_MIN: mode = 2'd2;
            SET_SEC: mode = 2'd3;
            default: mode = 2'd0;
        endcase
    end

    assign cnt_en    = (state_q == RUN) & tick_1hz;
    assign load      = (state_q == COMMIT);
    assign load_hour = load_val_q.hour;
    assign load_min  = load_val_q.min;
    assign load_sec  = load_val_q.sec;
    assign blink     = blink_q;

endmodule
